// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage.
// Handles boot, flush/branch redirects and a one-entry buffered branch.
module pc_gen #(
    parameter int                       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]        RESET_PC   = '0,
    parameter int                       INST_BYTES = 4,
    parameter int                       STALL_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                if_ready_i,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   flush_addr_i,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_i,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                ce_o,
    output logic                pending_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = STEP - ADDR_W'(1);

    state_t             state;
    logic [ADDR_W-1:0]  pend_pc;

    logic               advance;
    logic [ADDR_W-1:0]  flush_al;
    logic [ADDR_W-1:0]  br_al;
    logic               flush_mis;
    logic               br_mis;

    logic               do_flush;
    logic               do_br;
    logic               do_buf;
    logic               do_pend;
    logic               do_inc;

    // Only stall[0] matters to the PC; upper bits belong to later stages.
    logic               unused_stall;
    assign unused_stall = ^stall;

    assign advance   = ce_o & ~stall[0] & if_ready_i;
    assign flush_al  = flush_addr_i & ~LOW_MASK;
    assign br_al     = branch_target_i & ~LOW_MASK;
    assign flush_mis = |(flush_addr_i & LOW_MASK);
    assign br_mis    = |(branch_target_i & LOW_MASK);

    // One-hot decode of the redirect priority chain.
    always_comb begin
        do_flush = 1'b0;
        do_br    = 1'b0;
        do_buf   = 1'b0;
        do_pend  = 1'b0;
        do_inc   = 1'b0;
        if (flush_i) begin
            do_flush = 1'b1;
        end else if (branch_flag_i) begin
            do_br  = advance;
            do_buf = ~advance;
        end else if (advance) begin
            do_pend = (state == HOLD);
            do_inc  = (state == RUN);
        end
    end

    assign pending_o = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc_o       <= RESET_PC;
            pend_pc    <= RESET_PC;
            ce_o       <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            unique case (state)
                BOOT: begin
                    ce_o  <= 1'b1;
                    state <= RUN;
                end
                default: begin
                    unique case (1'b1)
                        do_flush: begin
                            pc_o       <= flush_al;
                            misalign_o <= flush_mis;
                            state      <= RUN;
                        end
                        do_br: begin
                            pc_o       <= br_al;
                            misalign_o <= br_mis;
                            state      <= RUN;
                        end
                        do_buf: begin
                            pend_pc    <= br_al;
                            misalign_o <= br_mis;
                            state      <= HOLD;
                        end
                        do_pend: begin
                            pc_o  <= pend_pc;
                            state <= RUN;
                        end
                        do_inc: begin
                            pc_o <= pc_o + STEP;
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios then random traffic,
// all checked against a behavioural model of the fetch address rules.
module tb_pc_gen;

    localparam int          AW   = 32;
    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam int          IB   = 4;

    logic           clk;
    logic           rst;
    logic [5:0]     stall;
    logic           if_ready_i;
    logic           flush_i;
    logic [31:0]    flush_addr_i;
    logic           branch_flag_i;
    logic [31:0]    branch_target_i;
    logic [31:0]    pc_o;
    logic           ce_o;
    logic           pending_o;
    logic           misalign_o;

    int n_chk;
    int n_bad;

    // model state
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_ce;
    logic        m_pend;
    logic        m_mis;
    logic        m_boot;

    pc_gen #(
        .ADDR_W    (AW),
        .RESET_PC  (RPC),
        .INST_BYTES(IB),
        .STALL_W   (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_ready_i     (if_ready_i),
        .flush_i        (flush_i),
        .flush_addr_i   (flush_addr_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .pc_o           (pc_o),
        .ce_o           (ce_o),
        .pending_o      (pending_o),
        .misalign_o     (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a - (a % IB);
    endfunction

    // What the fetch unit should look like after the coming clock edge.
    task automatic model_step();
        bit go;
        if (rst) begin
            m_pc = RPC; m_ce = 0; m_pend = 0; m_mis = 0; m_boot = 1;
            return;
        end
        m_mis = 0;
        if (m_boot) begin
            m_boot = 0; m_ce = 1;
            return;
        end
        go = m_ce && !stall[0] && if_ready_i;
        if (flush_i) begin
            m_pc = align(flush_addr_i); m_pend = 0;
            m_mis = (flush_addr_i % IB) != 0;
        end else if (branch_flag_i) begin
            m_mis = (branch_target_i % IB) != 0;
            if (go) begin
                m_pc = align(branch_target_i); m_pend = 0;
            end else begin
                m_tgt = align(branch_target_i); m_pend = 1;
            end
        end else if (go) begin
            if (m_pend) begin
                m_pc = m_tgt; m_pend = 0;
            end else begin
                m_pc = m_pc + IB;
            end
        end
    endtask

    task automatic step(input logic r, input logic [5:0] s, input logic rdy,
                        input logic f, input logic [31:0] fa,
                        input logic b, input logic [31:0] ba);
        rst = r; stall = s; if_ready_i = rdy;
        flush_i = f; flush_addr_i = fa;
        branch_flag_i = b; branch_target_i = ba;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("pc", pc_o, m_pc);
        check("ce", 32'(ce_o), 32'(m_ce));
        check("pend", 32'(pending_o), 32'(m_pend));
        check("mis", 32'(misalign_o), 32'(m_mis));
    endtask

    task automatic idle(input logic [5:0] s, input logic rdy);
        step(0, s, rdy, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        m_pc = 0; m_tgt = 0; m_ce = 0; m_pend = 0; m_mis = 0; m_boot = 1;
        rst = 1; stall = 0; if_ready_i = 0;
        flush_i = 0; flush_addr_i = 0; branch_flag_i = 0; branch_target_i = 0;
        @(negedge clk);

        // reset and boot
        repeat (3) step(1, 6'd0, 1, 0, 0, 0, 0);
        check("rst_pc", pc_o, 32'h8000_0000);
        check("rst_ce", 32'(ce_o), 32'd0);
        step(0, 6'd0, 1, 1, 32'h40, 1, 32'h50);
        check("boot_pc", pc_o, 32'h8000_0000);
        check("boot_ce", 32'(ce_o), 32'd1);
        idle(6'd0, 1);
        check("inc1", pc_o, 32'h8000_0004);
        idle(6'd0, 1);
        check("inc2", pc_o, 32'h8000_0008);

        // stall holds the pc
        step(0, 6'd0, 1, 1, 32'h10, 0, 0);
        check("fl10", pc_o, 32'h10);
        idle(6'b000001, 1);
        idle(6'b000001, 1);
        check("stall", pc_o, 32'h10);
        idle(6'b111110, 1);
        check("unstall", pc_o, 32'h14);

        // branch buffered during stall
        step(0, 6'b000001, 1, 0, 0, 1, 32'h200);
        check("buf_pend", 32'(pending_o), 32'd1);
        check("buf_pc", pc_o, 32'h14);
        idle(6'b000001, 1);
        check("buf_hold", 32'(pending_o), 32'd1);
        idle(6'd0, 1);
        check("buf_pc2", pc_o, 32'h200);
        check("buf_clr", 32'(pending_o), 32'd0);

        // flush beats branch
        step(0, 6'b000001, 1, 1, 32'h1000, 1, 32'h300);
        check("flprio", pc_o, 32'h1000);
        check("flpend", 32'(pending_o), 32'd0);

        // misaligned target and wrap
        step(0, 6'd0, 1, 0, 0, 1, 32'h203);
        check("mis_pc", pc_o, 32'h200);
        check("mis_on", 32'(misalign_o), 32'd1);
        idle(6'd0, 1);
        check("mis_off", 32'(misalign_o), 32'd0);
        step(0, 6'd0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        idle(6'd0, 1);
        check("wrap", pc_o, 32'h0);

        // reset while holding a branch
        step(0, 6'd0, 0, 0, 0, 1, 32'h480);
        check("hold_p", 32'(pending_o), 32'd1);
        step(1, 6'd0, 1, 0, 0, 0, 0);
        check("rh_pc", pc_o, 32'h8000_0000);
        check("rh_pend", 32'(pending_o), 32'd0);
        check("rh_ce", 32'(ce_o), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 6'($urandom) & {5'h1f, ($urandom_range(0, 3) == 0)},
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), $urandom,
                 ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
